// File: rtl/click_counter_pkg.sv
// click_counter_pkg: shared state type for the click burst counter.
package click_counter_pkg;
    typedef enum logic {IDLE, COUNTING} state_t;
endpackage

// File: rtl/click_counter.sv
// click_counter: groups debounced press pulses into bursts and reports presses per burst.
module click_counter
    import click_counter_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int WINDOW_MS  = 300,
    parameter int MAX_CLICKS = 3,
    localparam int CNT_W     = $clog2(MAX_CLICKS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             press,
    output logic             click_valid,
    output logic [CNT_W-1:0] click_count,
    output logic             busy
);
    localparam int WINDOW_CYCLES = (CLK_FREQ / 1000) * WINDOW_MS;
    localparam int TMR_W = $clog2(WINDOW_CYCLES) < 1 ? 1 : $clog2(WINDOW_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CLICKS);
    state_t state, state_n;
    logic [CNT_W-1:0] count, count_n, emit_count;
    logic [TMR_W-1:0] timer, timer_n;
    logic emit;
    always_comb begin
        state_n = state;
        count_n = count;
        timer_n = timer;
        emit = 1'b0;
        emit_count = count;
        if (state == IDLE) begin
            if (press) begin
                if (MAX_CLICKS == 1) begin
                    emit = 1'b1;
                    emit_count = CNT_W'(1);
                end else begin
                    state_n = COUNTING;
                    count_n = CNT_W'(1);
                    timer_n = '0;
                end
            end
        end else if (press) begin
            // a press in the terminal timer cycle wins over the timeout
            if (count + 1'b1 == CNT_MAX) begin
                emit = 1'b1;
                emit_count = CNT_MAX;
                state_n = IDLE;
                count_n = '0;
                timer_n = '0;
            end else begin
                count_n = count + 1'b1;
                timer_n = '0;
            end
        end else if (timer == TMR_LAST) begin
            emit = 1'b1;
            state_n = IDLE;
            count_n = '0;
            timer_n = '0;
        end else begin
            timer_n = timer + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            timer <= '0;
            click_valid <= 1'b0;
            click_count <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            timer <= timer_n;
            click_valid <= emit;
            if (emit) click_count <= emit_count;
        end
    end
    assign busy = (state == COUNTING);
endmodule
